// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data port share one memory port.
// Data wins by default; fetch is forced after STARVE_MAX consecutive data grants while it waits.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_ack,
    output logic        dm_err,
    output logic [63:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrate pending requests
    // IF_BUS | fetch owns the memory port, waiting for mem_rdy
    // DM_BUS | data access owns the port (or is a misaligned access being rejected)
    // RESP   | one-cycle ack to the granted master
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_BUS = 2'd1,
        DM_BUS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t        state, state_n;
    logic [SW-1:0] starve_cnt, starve_cnt_n;

    // Attributes of the granted access, held until the response is issued.
    logic          cap_we, cap_we_n;
    logic [1:0]    cap_size, cap_size_n;
    logic [2:0]    cap_off, cap_off_n;
    logic          cap_hi, cap_hi_n;
    logic          cap_misal, cap_misal_n;

    logic          mem_req_n, mem_we_n;
    logic [63:0]   mem_addr_n, mem_wdata_n;
    logic [7:0]    mem_be_n;
    logic          if_ack_n, dm_ack_n, dm_err_n, busy_n;
    logic [31:0]   if_rdata_n;
    logic [63:0]   dm_rdata_n;

    logic [7:0]    dm_be_base;
    logic [7:0]    dm_be;
    logic          dm_misal;
    logic [63:0]   dm_lane_wdata;
    logic [63:0]   rd_shift;
    logic [63:0]   rd_mask;
    logic          starve_ok;
    logic          unused_if_bits;

    assign unused_if_bits = ^if_addr[1:0];

    always_comb begin
        dm_be_base = 8'h01;
        dm_misal   = 1'b0;
        case (dm_size)
            2'd0: begin
                dm_be_base = 8'h01;
                dm_misal   = 1'b0;
            end
            2'd1: begin
                dm_be_base = 8'h03;
                dm_misal   = dm_addr[0];
            end
            2'd2: begin
                dm_be_base = 8'h0F;
                dm_misal   = |dm_addr[1:0];
            end
            default: begin
                dm_be_base = 8'hFF;
                dm_misal   = |dm_addr[2:0];
            end
        endcase
    end

    assign dm_be         = dm_be_base << dm_addr[2:0];
    assign dm_lane_wdata = dm_wdata << {dm_addr[2:0], 3'b000};

    // A shift of 64 yields zero, so the 8-byte case masks nothing.
    assign rd_shift  = mem_rdata >> {cap_off, 3'b000};
    assign rd_mask   = ~(64'hFFFF_FFFF_FFFF_FFFF << (7'd8 << cap_size));
    assign starve_ok = (starve_cnt < STARVE_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            cap_we     <= 1'b0;
            cap_size   <= 2'd0;
            cap_off    <= 3'd0;
            cap_hi     <= 1'b0;
            cap_misal  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 64'd0;
            mem_be     <= 8'd0;
            mem_wdata  <= 64'd0;
            if_ack     <= 1'b0;
            if_rdata   <= 32'd0;
            dm_ack     <= 1'b0;
            dm_err     <= 1'b0;
            dm_rdata   <= 64'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
            cap_we     <= cap_we_n;
            cap_size   <= cap_size_n;
            cap_off    <= cap_off_n;
            cap_hi     <= cap_hi_n;
            cap_misal  <= cap_misal_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_be     <= mem_be_n;
            mem_wdata  <= mem_wdata_n;
            if_ack     <= if_ack_n;
            if_rdata   <= if_rdata_n;
            dm_ack     <= dm_ack_n;
            dm_err     <= dm_err_n;
            dm_rdata   <= dm_rdata_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        starve_cnt_n = starve_cnt;
        cap_we_n     = cap_we;
        cap_size_n   = cap_size;
        cap_off_n    = cap_off;
        cap_hi_n     = cap_hi;
        cap_misal_n  = cap_misal;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_be_n     = mem_be;
        mem_wdata_n  = mem_wdata;
        if_ack_n     = 1'b0;
        if_rdata_n   = 32'd0;
        dm_ack_n     = 1'b0;
        dm_err_n     = 1'b0;
        dm_rdata_n   = 64'd0;

        case (state)
            IDLE: begin
                if (dm_req && (!if_req || starve_ok)) begin
                    state_n     = DM_BUS;
                    cap_we_n    = dm_we;
                    cap_size_n  = dm_size;
                    cap_off_n   = dm_addr[2:0];
                    cap_misal_n = dm_misal;
                    if (if_req) begin
                        starve_cnt_n = starve_cnt + SW'(1);
                    end
                    if (!dm_misal) begin
                        mem_req_n   = 1'b1;
                        mem_we_n    = dm_we;
                        mem_addr_n  = {dm_addr[63:3], 3'b000};
                        mem_be_n    = dm_be;
                        mem_wdata_n = dm_we ? dm_lane_wdata : 64'd0;
                    end
                end else if (if_req) begin
                    state_n      = IF_BUS;
                    starve_cnt_n = '0;
                    cap_hi_n     = if_addr[2];
                    mem_req_n    = 1'b1;
                    mem_we_n     = 1'b0;
                    mem_addr_n   = {if_addr[63:3], 3'b000};
                    mem_be_n     = if_addr[2] ? 8'hF0 : 8'h0F;
                    mem_wdata_n  = 64'd0;
                end
            end
            DM_BUS: begin
                if (cap_misal) begin
                    state_n  = RESP;
                    dm_ack_n = 1'b1;
                    dm_err_n = 1'b1;
                end else if (mem_rdy) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = 64'd0;
                    mem_be_n    = 8'd0;
                    mem_wdata_n = 64'd0;
                    dm_ack_n    = 1'b1;
                    dm_rdata_n  = cap_we ? 64'd0 : (rd_shift & rd_mask);
                end
            end
            IF_BUS: begin
                if (mem_rdy) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = 64'd0;
                    mem_be_n    = 8'd0;
                    mem_wdata_n = 64'd0;
                    if_ack_n    = 1'b1;
                    if_rdata_n  = cap_hi ? mem_rdata[63:32] : mem_rdata[31:0];
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a scoreboard of expected responses built from a
// byte-level reference model, with a memory responder of programmable wait states.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = 64'd0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [1:0]  dm_size = 2'd0;
    logic [63:0] dm_addr = 64'd0;
    logic [63:0] dm_wdata = 64'd0;
    logic        dm_ack;
    logic        dm_err;
    logic [63:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_rdy;
    logic [63:0] mem_rdata = 64'd0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int rdy_delay = 0;
    int wait_cnt = 0;

    typedef struct {
        logic        is_dm;
        logic        err;
        logic        memreq;
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    logic grant_q[$];

    int          o_ack_cyc, o_req_cyc;
    logic        o_ack2, o_unstable, o_we, o_err;
    logic [7:0]  o_be;
    logic [63:0] o_addr, o_wdata, o_rd;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && !mem_rdy) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mem_rdy = mem_req && (wait_cnt >= rdy_delay);

    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic [7:0] m_be(input logic [1:0] s, input int off);
        logic [7:0] r = 8'd0;
        for (int i = 0; i < nbytes(s); i++) if (off + i < 8) r[off + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int off);
        logic [63:0] r = 64'd0;
        for (int b = off; b < 8; b++) r[8*b +: 8] = wd[8*(b - off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_rdata(input logic [63:0] md, input logic [1:0] s, input int off);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < nbytes(s); i++) if (off + i < 8) r[8*i +: 8] = md[8*(off + i) +: 8];
        return r;
    endfunction

    function automatic logic m_misal(input logic [63:0] a, input logic [1:0] s);
        return (int'(a[2:0]) % nbytes(s)) != 0;
    endfunction

    // Observation window: cycle 0 is the cycle the request is first presented in IDLE.
    task automatic observe(input logic want_dm);
        logic       first = 1'b1;
        logic [7:0] be0;
        logic [63:0] a0, w0;
        logic       we0;
        o_ack_cyc = -1; o_req_cyc = 0; o_unstable = 1'b0;
        be0 = 8'd0; a0 = 64'd0; w0 = 64'd0; we0 = 1'b0;
        for (int c = 0; c < 60 && o_ack_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_req) begin
                o_req_cyc++;
                if (first) begin
                    be0 = mem_be; a0 = mem_addr; w0 = mem_wdata; we0 = mem_we; first = 1'b0;
                end else if (mem_be !== be0 || mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) begin
                    o_unstable = 1'b1;
                end
            end
            if (want_dm ? dm_ack : if_ack) begin
                o_ack_cyc = c; o_rd = want_dm ? dm_rdata : {32'd0, if_rdata}; o_err = dm_err;
            end
        end
        o_be = be0; o_addr = a0; o_wdata = w0; o_we = we0;
        @(posedge clk); #1;
        dm_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        o_ack2 = want_dm ? dm_ack : if_ack;
    endtask

    task automatic do_dm(input logic we, input logic [1:0] sz, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] md, input int dly);
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = we; dm_size = sz; dm_addr = a; dm_wdata = wd;
        mem_rdata = md; rdy_delay = dly;
        observe(1'b1);
    endtask

    task automatic do_if(input logic [63:0] a, input logic [63:0] md, input int dly);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a; mem_rdata = md; rdy_delay = dly;
        observe(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, dm_ack, dm_err, if_rdata, dm_rdata, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wd=%h ia=%b da=%b err=%b ird=%h drd=%h busy=%b want all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, dm_ack, dm_err, if_rdata, dm_rdata, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_common(input string nm, input exp_t e, input int want_ack, input int want_req);
        vectors++;
        if (o_ack_cyc !== want_ack) begin
            miscompares++; $display("FAIL %s ack_cycle: got %0d want %0d", nm, o_ack_cyc, want_ack);
        end
        vectors++;
        if (o_req_cyc !== want_req) begin
            miscompares++; $display("FAIL %s mem_req_cycles: got %0d want %0d", nm, o_req_cyc, want_req);
        end
        vectors++;
        if (o_rd !== e.rdata) begin
            miscompares++; $display("FAIL %s rdata: got %h want %h", nm, o_rd, e.rdata);
        end
        vectors++;
        if (o_ack2 !== 1'b0 || o_unstable !== 1'b0) begin
            miscompares++; $display("FAIL %s ack_pulse_or_stability: got ack2=%b unstable=%b want 0 0", nm, o_ack2, o_unstable);
        end
    endtask

    task automatic test_load();
        logic [1:0]  szs[4]  = '{2'd2, 2'd0, 2'd3, 2'd1};
        logic [63:0] adrs[4] = '{64'h104, 64'h107, 64'h100, 64'h10A};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            logic [63:0] md = (i == 0) ? 64'h89AB_CDEF_0123_4567 : 64'h1122_3344_5566_7788;
            e = '{is_dm: 1'b1, err: 1'b0, memreq: 1'b1, we: 1'b0, be: m_be(szs[i], int'(adrs[i][2:0])),
                  addr: adrs[i] & ~64'h7, wdata: 64'd0, rdata: m_rdata(md, szs[i], int'(adrs[i][2:0]))};
            sb.push_back(e);
            do_dm(1'b0, szs[i], adrs[i], 64'hDEAD_BEEF, md, 0);
            e = sb.pop_front();
            check_common($sformatf("load%0d", i), e, 2, 1);
            vectors++;
            if (o_be !== e.be || o_addr !== e.addr || o_we !== 1'b0 || o_err !== 1'b0) begin
                miscompares++;
                $display("FAIL load%0d port: got be=%h addr=%h we=%b err=%b want be=%h addr=%h we=0 err=0",
                         i, o_be, o_addr, o_we, o_err, e.be, e.addr);
            end
        end
    endtask

    task automatic test_store();
        logic [1:0]  szs[3]  = '{2'd0, 2'd3, 2'd1};
        logic [63:0] adrs[3] = '{64'h13, 64'h118, 64'h116};
        logic [63:0] wds[3]  = '{64'hAA, 64'h0123_4567_89AB_CDEF, 64'hBEEF};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = '{is_dm: 1'b1, err: 1'b0, memreq: 1'b1, we: 1'b1, be: m_be(szs[i], int'(adrs[i][2:0])),
                  addr: adrs[i] & ~64'h7, wdata: m_wdata(wds[i], int'(adrs[i][2:0])), rdata: 64'd0};
            sb.push_back(e);
            do_dm(1'b1, szs[i], adrs[i], wds[i], 64'hFFFF_FFFF_FFFF_FFFF, i);
            e = sb.pop_front();
            check_common($sformatf("store%0d", i), e, 2 + i, 1 + i);
            vectors++;
            if (o_be !== e.be || o_addr !== e.addr || o_wdata !== e.wdata || o_we !== 1'b1 || o_err !== 1'b0) begin
                miscompares++;
                $display("FAIL store%0d port: got be=%h addr=%h wd=%h we=%b err=%b want be=%h addr=%h wd=%h we=1 err=0",
                         i, o_be, o_addr, o_wdata, o_we, o_err, e.be, e.addr, e.wdata);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  szs[3]  = '{2'd3, 2'd1, 2'd2};
        logic [63:0] adrs[3] = '{64'h9, 64'h101, 64'h102};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = '{is_dm: 1'b1, err: m_misal(adrs[i], szs[i]), memreq: 1'b0, we: 1'b0, be: 8'd0,
                  addr: 64'd0, wdata: 64'd0, rdata: 64'd0};
            sb.push_back(e);
            do_dm(i == 1, szs[i], adrs[i], 64'h55, 64'h1234_5678_9ABC_DEF0, 0);
            e = sb.pop_front();
            check_common($sformatf("misal%0d", i), e, 2, 0);
            vectors++;
            if (o_err !== e.err) begin
                miscompares++; $display("FAIL misal%0d dm_err: got %b want %b", i, o_err, e.err);
            end
        end
    endtask

    task automatic test_fetch();
        logic [63:0] adrs[2] = '{64'h204, 64'h300};
        int          dly[2]  = '{2, 0};
        logic [63:0] md = 64'h89AB_CDEF_0123_4567;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = '{is_dm: 1'b0, err: 1'b0, memreq: 1'b1, we: 1'b0, be: adrs[i][2] ? 8'hF0 : 8'h0F,
                  addr: adrs[i] & ~64'h7, wdata: 64'd0,
                  rdata: {32'd0, adrs[i][2] ? md[63:32] : md[31:0]}};
            sb.push_back(e);
            do_if(adrs[i], md, dly[i]);
            e = sb.pop_front();
            check_common($sformatf("fetch%0d", i), e, 2 + dly[i], 1 + dly[i]);
            vectors++;
            if (o_be !== e.be || o_addr !== e.addr || o_we !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch%0d port: got be=%h addr=%h we=%b want be=%h addr=%h we=0",
                         i, o_be, o_addr, o_we, e.be, e.addr);
            end
        end
    endtask

    task automatic test_starve();
        int  cyc = 0;
        logic g;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) grant_q.push_back(1'b1);
            grant_q.push_back(1'b0);
        end
        @(posedge clk); #1;
        rdy_delay = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd3; dm_addr = 64'h100;
        if_req = 1'b1; if_addr = 64'h200;
        while (grant_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (if_ack && dm_ack) begin
                vectors++; miscompares++;
                $display("FAIL starve_dual_ack: got if_ack=1 dm_ack=1 want at most one");
            end else if (if_ack || dm_ack) begin
                g = grant_q.pop_front();
                vectors++;
                if (dm_ack !== g) begin
                    miscompares++;
                    $display("FAIL starve_order: got %s want %s", dm_ack ? "D" : "I", g ? "D" : "I");
                end
            end
        end
        vectors++;
        if (grant_q.size() != 0) begin
            miscompares++;
            $display("FAIL starve_timeout: got %0d grants outstanding want 0", grant_q.size());
            grant_q.delete();
        end
        @(posedge clk); #1;
        dm_req = 1'b0; if_req = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd3; dm_addr = 64'h100; rdy_delay = 100;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_started: got mem_req=%b busy=%b want 1 1", mem_req, busy);
        end
        rst_n = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_dropped: got mem_req=%b busy=%b want 0 0", mem_req, busy);
        end
        rdy_delay = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dm_ack || if_ack) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++; $display("FAIL rstmid_no_ack: got %0d acks want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_fetch();
        test_starve();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
